// File: rtl/ulpi_phy_cmd_pkg.sv
// ulpi_phy_cmd_pkg: shared ULPI constants (TX CMD bytes, register addresses,
// function-control values) and the sequencer state encodings.
// No ports; imported by the sequencer, its interface users and the bench.
package ulpi_phy_cmd_pkg;

    localparam logic [7:0] TXCMD_NOPID = 8'h40;
    localparam logic [7:0] TXCMD_REGW  = 8'h80;
    localparam logic [7:0] TXCMD_REGR  = 8'hC0;

    localparam logic [5:0] REG_FUNC_CTRL = 6'h04;
    localparam logic [5:0] REG_OTG_CTRL  = 6'h0A;

    localparam logic [7:0] FCTRL_FS    = 8'h45;
    localparam logic [7:0] FCTRL_CHIRP = 8'h54;
    localparam logic [7:0] FCTRL_HS    = 8'h40;

    // State encodings, exposed so debug probes can decode the FSM.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REG_CMD  = 3'd1;
    localparam logic [2:0] ST_REG_DATA = 3'd2;
    localparam logic [2:0] ST_REG_STP  = 3'd3;
    localparam logic [2:0] ST_NOP_CMD  = 3'd4;
    localparam logic [2:0] ST_NOP_HOLD = 3'd5;
    localparam logic [2:0] ST_NOP_STP  = 3'd6;
    localparam logic [2:0] ST_TURN     = 3'd7;

    function automatic logic [7:0] regw_cmd(input logic [5:0] addr);
        return TXCMD_REGW | {2'b00, addr};
    endfunction

endpackage

// File: rtl/ulpi_phy_cmd_if.sv
// ulpi_phy_cmd_if: request/response handshake between the line-state FSM
// (master) and the ULPI PHY command sequencer (slave).
//   write, nopid : level requests (register write / NOPID chirp)
//   stop         : one-cycle pulse ending a NOPID transmit
//   addr, data   : TX CMD byte and register value for a write
//   busy, done, error : sequencer progress reported back to the requester
interface ulpi_phy_cmd_if;

    logic       write;
    logic       nopid;
    logic       stop;
    logic [7:0] addr;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output write, nopid, stop, addr, data,
        input  busy, done, error
    );

    modport slave (
        input  write, nopid, stop, addr, data,
        output busy, done, error
    );

endinterface

// File: rtl/ulpi_phy_cmd.sv
// ulpi_phy_cmd: link-side ULPI transmit sequencer for PHY control traffic.
// Turns register-write and NOPID/stop requests into TX CMD, data and stp
// cycles on the ULPI bus, with dir-abort and nxt-timeout handling.
//   clock, reset     : ULPI clock, synchronous active-high reset
//   ulpi_dir/nxt     : raw PHY pins, sampled at clock edges
//   ulpi_stp_o       : registered stp to pad
//   ulpi_data_o/_oe_o: registered link-driven data and its drive enable
//   phy              : request/response handshake (slave side)
module ulpi_phy_cmd
    import ulpi_phy_cmd_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TCW     = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ulpi_dir,
    input  logic         ulpi_nxt,
    output logic         ulpi_stp_o,
    output logic [7:0]   ulpi_data_o,
    output logic         ulpi_data_oe_o,
    ulpi_phy_cmd_if.slave phy
);

    logic [2:0]     state;
    logic           dir_q;
    logic [TCW-1:0] cnt;
    logic           stop_pending;
    logic [7:0]     wr_data;

    logic in_abortable;
    logic in_wait;

    // States in which the PHY can seize the bus and abort the sequence.
    assign in_abortable = state == ST_REG_CMD || state == ST_REG_DATA ||
                          state == ST_NOP_CMD || state == ST_NOP_HOLD;
    // States that wait for nxt and are therefore guarded by the timeout.
    assign in_wait      = state == ST_REG_CMD || state == ST_REG_DATA ||
                          state == ST_NOP_CMD;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            dir_q          <= 1'b0;
            cnt            <= '0;
            stop_pending   <= 1'b0;
            wr_data        <= 8'h00;
            ulpi_stp_o     <= 1'b0;
            ulpi_data_o    <= 8'h00;
            ulpi_data_oe_o <= 1'b0;
            phy.busy       <= 1'b0;
            phy.done       <= 1'b0;
            phy.error      <= 1'b0;
        end else begin
            dir_q     <= ulpi_dir;
            phy.done  <= 1'b0;
            phy.error <= 1'b0;
            if (in_abortable && ulpi_dir) begin
                // PHY owns the bus: release the pads and wait out turnaround.
                state          <= ST_TURN;
                stop_pending   <= 1'b0;
                ulpi_stp_o     <= 1'b0;
                ulpi_data_o    <= 8'h00;
                ulpi_data_oe_o <= 1'b0;
            end else if (in_wait) begin
                if (state == ST_NOP_CMD && phy.stop)
                    stop_pending <= 1'b1;
                if (ulpi_nxt) begin
                    cnt <= '0;
                    if (state == ST_REG_CMD) begin
                        state       <= ST_REG_DATA;
                        ulpi_data_o <= wr_data;
                    end else if (state == ST_REG_DATA) begin
                        state       <= ST_REG_STP;
                        ulpi_stp_o  <= 1'b1;
                        ulpi_data_o <= 8'h00;
                        phy.done    <= 1'b1;
                    end else begin
                        state       <= ST_NOP_HOLD;
                        ulpi_data_o <= 8'h00;
                        phy.done    <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                    // Abort on the edge where the count would reach TIMEOUT.
                    if (cnt == TCW'(TIMEOUT - 1)) begin
                        state        <= (state == ST_NOP_CMD) ? ST_NOP_STP : ST_REG_STP;
                        stop_pending <= 1'b0;
                        ulpi_stp_o   <= 1'b1;
                        ulpi_data_o  <= 8'h00;
                        phy.error    <= 1'b1;
                    end
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!ulpi_dir && !dir_q && (phy.write || phy.nopid)) begin
                            cnt            <= '0;
                            stop_pending   <= 1'b0;
                            ulpi_data_oe_o <= 1'b1;
                            phy.busy       <= 1'b1;
                            wr_data        <= phy.data;
                            state          <= phy.write ? ST_REG_CMD : ST_NOP_CMD;
                            ulpi_data_o    <= phy.write ? phy.addr : TXCMD_NOPID;
                        end
                    end
                    ST_NOP_HOLD: begin
                        if (phy.stop || stop_pending) begin
                            state        <= ST_NOP_STP;
                            stop_pending <= 1'b0;
                            ulpi_stp_o   <= 1'b1;
                            ulpi_data_o  <= 8'h00;
                        end
                    end
                    ST_REG_STP, ST_NOP_STP: begin
                        state          <= ST_IDLE;
                        ulpi_stp_o     <= 1'b0;
                        ulpi_data_o    <= 8'h00;
                        ulpi_data_oe_o <= 1'b0;
                        phy.busy       <= 1'b0;
                    end
                    ST_TURN: begin
                        if (!ulpi_dir && !dir_q) begin
                            state    <= ST_IDLE;
                            phy.busy <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
